// File: rtl/headercap_def.sv
// Shared definitions for the rule-memory debug readback path: rule geometry,
// debug address field layout and the readback arbiter state encoding.
package headercap_def;

    localparam int CONCAT_WIDTH = 120;
    localparam int DBG_WORDS    = (CONCAT_WIDTH + 31) / 32;

    // The debug word index is two bits wide, so a readable rule spans at most 4 words
    localparam int DBG_SPAN_W   = 4 * 32;

    // avs_dbg_address = {bank_sel, rule_idx[8:0], word[1:0]}
    localparam int DBG_WORD_LSB = 0;
    localparam int DBG_WORD_W   = 2;
    localparam int DBG_IDX_LSB  = 2;
    localparam int DBG_IDX_W    = 9;
    localparam int DBG_SEL_BIT  = 11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_WAIT_SLOT,
        ST_FETCH,
        ST_RESP
    } rb_state_t;

endpackage

// File: rtl/rule_word_cache.sv
// Single-entry cache of the last rule fetched for debug readback: tag, valid,
// the full rule register and the 32-bit word select with zero padding.
module rule_word_cache
    import headercap_def::*;
#(
    parameter int CONCAT_WIDTH = headercap_def::CONCAT_WIDTH
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    capture,
    input  logic                    cap_bank,
    input  logic [DBG_IDX_W-1:0]    cap_idx,
    input  logic [CONCAT_WIDTH-1:0] cap_data,
    input  logic [1:0]              rule_wren,
    input  logic                    bank_toggle,
    input  logic                    look_bank,
    input  logic [DBG_IDX_W-1:0]    look_idx,
    output logic                    hit,
    input  logic [DBG_WORD_W-1:0]   word,
    output logic [31:0]             word_data
);

    logic                    valid_q;
    logic                    tag_bank_q;
    logic [DBG_IDX_W-1:0]    tag_idx_q;
    logic [CONCAT_WIDTH-1:0] data_q;
    logic                    invalidate;
    logic [DBG_SPAN_W-1:0]   padded;

    // A write to the cached bank, or to the bank being captured right now,
    // makes the entry stale; so does any swap of the active bank.
    assign invalidate = bank_toggle
                      || (valid_q && rule_wren[tag_bank_q])
                      || (capture && rule_wren[cap_bank]);

    assign hit = valid_q && (tag_bank_q == look_bank) && (tag_idx_q == look_idx);

    // Bits above the rule width read back as zero
    assign padded    = DBG_SPAN_W'(data_q);
    assign word_data = (int'(word) < DBG_WORDS) ? padded[{word, 5'd0} +: 32] : 32'd0;

    // Tag and valid tracking; a capture that races an invalidation keeps its data but not its valid
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q    <= 1'b0;
            tag_bank_q <= 1'b0;
            tag_idx_q  <= '0;
        end else if (capture) begin
            valid_q    <= !invalidate;
            tag_bank_q <= cap_bank;
            tag_idx_q  <= cap_idx;
        end else if (invalidate) begin
            valid_q    <= 1'b0;
        end
    end

    // Rule data register, qualified by valid_q so it needs no reset
    always_ff @(posedge clock) begin
        if (capture) begin
            data_q <= cap_data;
        end
    end

endmodule

// File: rtl/rulemem_readback_arbiter.sv
// Arbitrates port B of the double-buffered rule memories between the search
// engine (priority) and the Avalon-MM debug readback slave. Readback takes idle
// slots, or forces one stall cycle once it has waited STARVE_LIMIT cycles.
module rulemem_readback_arbiter
    import headercap_def::*;
#(
    parameter int CONCAT_WIDTH = headercap_def::CONCAT_WIDTH,
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 15
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    srch_active,
    input  logic [8:0]              srch_addr,
    output logic                    srch_stall,
    output logic [8:0]              mem_addr,
    input  logic [CONCAT_WIDTH-1:0] mem_q0,
    input  logic [CONCAT_WIDTH-1:0] mem_q1,
    input  logic                    bigactive,
    input  logic [9:0]              rulecount,
    input  logic [1:0]              rule_wren,
    input  logic [11:0]             avs_dbg_address,
    input  logic                    avs_dbg_read,
    output logic [31:0]             avs_dbg_readdata,
    output logic                    avs_dbg_waitrequest,
    output logic                    avs_dbg_readdatavalid
);

    localparam int LAT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam int STV_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    rb_state_t               state_q;
    logic                    sel_q;
    logic                    bank_q;
    logic                    oob_q;
    logic                    bigactive_q;
    logic [DBG_IDX_W-1:0]    idx_q;
    logic [DBG_WORD_W-1:0]   word_q;
    logic [STV_W-1:0]        starve_q;
    logic [LAT_W-1:0]        lat_q;

    logic                    grant;
    logic                    capture;
    logic                    out_of_range;
    logic                    cache_hit;
    logic                    bank_toggle;
    logic [CONCAT_WIDTH-1:0] cap_data;
    logic [31:0]             cache_word;

    // The slot is taken in the same cycle the wait is resolved, so this
    // cycle is the single issue cycle that drives the rule address to memory.
    assign grant = (state_q == ST_WAIT_SLOT)
                && (!srch_active || (starve_q == STV_W'(STARVE_LIMIT)));

    assign capture      = (state_q == ST_FETCH) && (lat_q == LAT_W'(MEM_LATENCY - 1));
    assign out_of_range = !sel_q && ({1'b0, idx_q} >= rulecount);
    assign bank_toggle  = bigactive ^ bigactive_q;
    assign cap_data     = bank_q ? mem_q1 : mem_q0;

    assign mem_addr   = grant ? idx_q : srch_addr;
    assign srch_stall = grant && srch_active;

    assign avs_dbg_waitrequest   = (state_q != ST_IDLE);
    assign avs_dbg_readdatavalid = (state_q == ST_RESP);
    assign avs_dbg_readdata      = ((state_q == ST_RESP) && !oob_q) ? cache_word : 32'd0;

    rule_word_cache #(
        .CONCAT_WIDTH (CONCAT_WIDTH)
    ) u_cache (
        .clock       (clock),
        .reset       (reset),
        .capture     (capture),
        .cap_bank    (bank_q),
        .cap_idx     (idx_q),
        .cap_data    (cap_data),
        .rule_wren   (rule_wren),
        .bank_toggle (bank_toggle),
        .look_bank   (bank_q),
        .look_idx    (idx_q),
        .hit         (cache_hit),
        .word        (word_q),
        .word_data   (cache_word)
    );

    // Previous active bank, used to spot a bank swap
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bigactive_q <= 1'b0;
        end else begin
            bigactive_q <= bigactive;
        end
    end

    // Readback sequencer: accept, look up, wait for a slot, fetch, respond
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            sel_q    <= 1'b0;
            bank_q   <= 1'b0;
            oob_q    <= 1'b0;
            idx_q    <= '0;
            word_q   <= '0;
            starve_q <= '0;
            lat_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (avs_dbg_read) begin
                        // Physical bank is resolved once here and never re-evaluated
                        sel_q   <= avs_dbg_address[DBG_SEL_BIT];
                        bank_q  <= avs_dbg_address[DBG_SEL_BIT] ^ bigactive;
                        idx_q   <= avs_dbg_address[DBG_IDX_LSB +: DBG_IDX_W];
                        word_q  <= avs_dbg_address[DBG_WORD_LSB +: DBG_WORD_W];
                        oob_q   <= 1'b0;
                        state_q <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    if (out_of_range) begin
                        oob_q   <= 1'b1;
                        state_q <= ST_RESP;
                    end else if (cache_hit) begin
                        state_q <= ST_RESP;
                    end else begin
                        state_q <= ST_WAIT_SLOT;
                    end
                end
                ST_WAIT_SLOT: begin
                    if (grant) begin
                        lat_q   <= '0;
                        state_q <= ST_FETCH;
                    end else begin
                        starve_q <= starve_q + 1'b1;
                    end
                end
                ST_FETCH: begin
                    if (capture) begin
                        state_q <= ST_RESP;
                    end else begin
                        lat_q <= lat_q + 1'b1;
                    end
                end
                ST_RESP: begin
                    starve_q <= '0;
                    state_q  <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
